uart_tx_unit: RTL and testbench

UART_TX_UNIT -- requirements
Module: uart_tx_unit

---
 rtl/uart_tx_unit.sv | 180 ++++++++++++++++++
 tb/tb_uart_tx_unit.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_unit.sv
// UART transmitter: 2^FIFO_W-entry byte FIFO feeding a 16x-oversampled serial framer.
// Frame = start bit, DBIT data bits LSB first, SB_TICK/16 stop bits; tx is a registered output.
//
// state  | meaning
// IDLE   | line high, waiting for a FIFO entry
// START  | start bit (low) for 16 ticks
// DATA   | DBIT data bits, 16 ticks each, LSB first
// STOP   | line high for SB_TICK ticks, then done pulse
module uart_tx_unit #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16,
    parameter int DVSR    = 326,
    parameter int FIFO_W  = 4
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       wr_uart,
    input  logic [7:0] w_data,
    output logic       tx_full,
    output logic       tx_empty,
    output logic       tx_busy,
    output logic       tx_done_tick,
    output logic       tx
);

    localparam int DEPTH = 1 << FIFO_W;
    localparam int C_W   = (DVSR > 1) ? $clog2(DVSR) : 1;
    localparam int S_W   = $clog2((SB_TICK > 16) ? SB_TICK : 16);
    localparam int N_W   = (DBIT > 1) ? $clog2(DBIT) : 1;

    localparam logic [C_W-1:0] C_LAST      = C_W'(DVSR - 1);
    localparam logic [S_W-1:0] S_BIT_LAST  = S_W'(15);
    localparam logic [S_W-1:0] S_STOP_LAST = S_W'(SB_TICK - 1);
    localparam logic [N_W-1:0] N_LAST      = N_W'(DBIT - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    logic [DBIT-1:0]   mem [DEPTH];
    logic [FIFO_W-1:0] wptr, rptr, wptr_nxt, rptr_nxt;
    logic              full_q, empty_q;
    logic              push, pop;

    logic [1:0]        state;
    logic [C_W-1:0]    cnt;
    logic              tick;
    logic [S_W-1:0]    s_cnt;
    logic [N_W-1:0]    n_cnt;
    logic [DBIT-1:0]   shreg;
    logic              tx_q, tx_nxt, done_q;
    logic              start_frame;

    assign start_frame = (state == ST_IDLE) && !empty_q;

    // A write against a full FIFO is dropped even if a pop frees a slot this cycle.
    assign push     = wr_uart && !full_q;
    assign pop      = start_frame;
    assign wptr_nxt = wptr + 1'b1;
    assign rptr_nxt = rptr + 1'b1;

    always_ff @(posedge i_clk) begin
        if (push && !i_rst)
            mem[wptr] <= w_data[DBIT-1:0];
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wptr    <= '0;
            rptr    <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            case ({push, pop})
                2'b10: begin
                    wptr    <= wptr_nxt;
                    empty_q <= 1'b0;
                    full_q  <= (wptr_nxt == rptr);
                end
                2'b01: begin
                    rptr    <= rptr_nxt;
                    full_q  <= 1'b0;
                    empty_q <= (rptr_nxt == wptr);
                end
                2'b11: begin
                    wptr <= wptr_nxt;
                    rptr <= rptr_nxt;
                end
                default: ;
            endcase
        end
    end

    // Baud counter restarts with each frame so the start bit is a full 16 ticks.
    assign tick = (cnt == C_LAST);

    always_ff @(posedge i_clk) begin
        if (i_rst || start_frame || tick)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

    always_comb begin
        tx_nxt = 1'b1;
        case (state)
            ST_START: tx_nxt = 1'b0;
            ST_DATA:  tx_nxt = shreg[0];
            default:  tx_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state  <= ST_IDLE;
            s_cnt  <= '0;
            n_cnt  <= '0;
            shreg  <= '0;
            tx_q   <= 1'b1;
            done_q <= 1'b0;
        end else begin
            tx_q   <= tx_nxt;
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_frame) begin
                        shreg <= mem[rptr];
                        s_cnt <= '0;
                        n_cnt <= '0;
                        state <= ST_START;
                    end
                end
                ST_START: begin
                    if (tick) begin
                        if (s_cnt == S_BIT_LAST) begin
                            s_cnt <= '0;
                            n_cnt <= '0;
                            state <= ST_DATA;
                        end else begin
                            s_cnt <= s_cnt + 1'b1;
                        end
                    end
                end
                ST_DATA: begin
                    if (tick) begin
                        if (s_cnt == S_BIT_LAST) begin
                            s_cnt <= '0;
                            shreg <= shreg >> 1;
                            if (n_cnt == N_LAST)
                                state <= ST_STOP;
                            else
                                n_cnt <= n_cnt + 1'b1;
                        end else begin
                            s_cnt <= s_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    if (tick) begin
                        if (s_cnt == S_STOP_LAST) begin
                            s_cnt  <= '0;
                            done_q <= 1'b1;
                            state  <= ST_IDLE;
                        end else begin
                            s_cnt <= s_cnt + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    assign tx           = tx_q;
    assign tx_done_tick = done_q;
    assign tx_busy      = (state != ST_IDLE);
    assign tx_full      = full_q;
    assign tx_empty     = empty_q;

endmodule

// File: tb/tb_uart_tx_unit.sv
// Bench for uart_tx_unit: queue-level reference model plus a serial-line decoder scoreboard,
// and a directed waveform check of a DBIT=7 / two-stop-bit instance.
module tb_uart_tx_unit;

    localparam int DVSR    = 4;
    localparam int DBIT    = 8;
    localparam int SB_TICK = 16;
    localparam int DEPTH   = 16;
    localparam int BIT     = 16 * DVSR;
    localparam int FRAME   = (16 * (1 + DBIT) + SB_TICK) * DVSR;
    localparam int STOP_MID = BIT * (1 + DBIT) + SB_TICK * DVSR / 2;
    localparam int FRAME7  = (16 * (1 + 7) + 32) * DVSR;

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b1;
    logic       wr_uart = 1'b0;
    logic [7:0] w_data = 8'h00;
    logic       tx_full, tx_empty, tx_busy, tx_done_tick, tx;

    logic       wr7 = 1'b0;
    logic [7:0] wdata7 = 8'h00;
    logic       full7, empty7, busy7, done7, tx7;

    uart_tx_unit #(.DBIT(DBIT), .SB_TICK(SB_TICK), .DVSR(DVSR), .FIFO_W(4)) u_dut (
        .i_clk(i_clk), .i_rst(i_rst), .wr_uart(wr_uart), .w_data(w_data),
        .tx_full(tx_full), .tx_empty(tx_empty), .tx_busy(tx_busy),
        .tx_done_tick(tx_done_tick), .tx(tx)
    );

    uart_tx_unit #(.DBIT(7), .SB_TICK(32), .DVSR(DVSR), .FIFO_W(4)) u_dut7 (
        .i_clk(i_clk), .i_rst(i_rst), .wr_uart(wr7), .w_data(wdata7),
        .tx_full(full7), .tx_empty(empty7), .tx_busy(busy7),
        .tx_done_tick(done7), .tx(tx7)
    );

    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_err = 0;
    int cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: FIFO contents and the time the framer stays busy after a pop.
    int mq[$];
    int exp_q[$];
    int busy = 0;
    int last_pop = -10;
    int n_push = 0;
    bit rst_edge = 1'b0;
    bit started = 1'b0;

    always @(posedge i_clk) begin
        bit pop_now;
        bit push_now;
        cyc++;
        rst_edge = i_rst;
        if (i_rst) begin
            started = 1'b1;
            mq.delete();
            exp_q.delete();
            busy = 0;
        end else begin
            pop_now  = (busy == 0) && (mq.size() > 0);
            push_now = wr_uart && (mq.size() < DEPTH);
            if (pop_now) begin
                exp_q.push_back(mq.pop_front());
                busy = FRAME;
                last_pop = cyc;
            end else if (busy > 0) begin
                busy--;
            end
            if (push_now) begin
                mq.push_back(int'(w_data) & ((1 << DBIT) - 1));
                n_push++;
            end
        end
    end

    always @(negedge i_clk) begin
        if (started) begin
            chk("tx_full", tx_full, mq.size() == DEPTH);
            chk("tx_empty", tx_empty, mq.size() == 0);
            chk("tx_busy", tx_busy, busy > 0);
        end
    end

    // Line monitor: decodes each frame from tx and scores it against the expected queue.
    bit         mon_active = 1'b0;
    int         mon_t = 0;
    logic [7:0] mon_byte = 8'h00;
    int         frames_done = 0;

    always @(negedge i_clk) begin
        if (started) begin
            if (rst_edge) begin
                mon_active = 1'b0;
                chk("tx_after_reset", tx, 1);
                chk("done_after_reset", tx_done_tick, 0);
            end else begin
                if (!mon_active) begin
                    chk("done_idle", tx_done_tick, 0);
                    if (tx === 1'b0) begin
                        mon_active = 1'b1;
                        mon_t = 0;
                        mon_byte = 8'h00;
                        chk("frame_queued", exp_q.size() > 0, 1);
                        chk("start_latency", cyc, last_pop + 1);
                    end
                end
                if (mon_active) begin
                    chk("done_pulse", tx_done_tick, mon_t == FRAME - 1);
                    if (mon_t == BIT / 2)
                        chk("start_bit", tx, 0);
                    if (mon_t > BIT && mon_t < BIT * (DBIT + 1) && (mon_t % BIT) == BIT / 2)
                        mon_byte[mon_t / BIT - 1] = tx;
                    if (mon_t == STOP_MID || mon_t == FRAME - 1)
                        chk("stop_bit", tx, 1);
                    if (mon_t == FRAME - 1) begin
                        chk("frame_expected", exp_q.size() > 0, 1);
                        if (exp_q.size() > 0)
                            chk("frame_data", mon_byte, exp_q.pop_front());
                        frames_done++;
                        mon_active = 1'b0;
                    end else begin
                        mon_t++;
                    end
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    task automatic wr(input logic [7:0] d);
        wr_uart = 1'b1;
        w_data = d;
        step(1);
        wr_uart = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while (!(mq.size() == 0 && busy == 0 && !mon_active) && k < budget) begin
            step(1);
            k++;
        end
        chk("drain_in_time", k < budget, 1);
        step(2);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int f0, p0, k;
        logic [7:0] byte7;
        logic exp_tx;
        int d;

        i_rst = 1'b1;
        step(3);
        i_rst = 1'b0;
        step(2);

        f0 = frames_done;
        wr(8'h55);
        wait_idle(2000);
        chk("single_frame_count", frames_done - f0, 1);

        f0 = frames_done;
        wr(8'hA3);
        wr(8'h0F);
        wait_idle(3000);
        chk("pair_frame_count", frames_done - f0, 2);

        // 18 back-to-back writes: one is popped at once, 16 fill the FIFO, the last is dropped.
        f0 = frames_done;
        for (int i = 0; i < 18; i++)
            wr(8'($urandom_range(0, 255)));
        wait_idle(15000);
        chk("burst_frame_count", frames_done - f0, 17);

        // Hold wr_uart high while full so writes collide with pops.
        f0 = frames_done;
        p0 = n_push;
        wr_uart = 1'b1;
        repeat (717) begin
            w_data = 8'($urandom_range(0, 255));
            step(1);
        end
        wr_uart = 1'b0;
        wait_idle(16000);
        chk("hold_frame_count", frames_done - f0, n_push - p0);

        // Push in the same cycle the last resident entry is popped.
        f0 = frames_done;
        wr(8'h3C);
        wr(8'hC5);
        k = 0;
        while (!(busy == 0 && mq.size() == 1) && k < 2000) begin
            step(1);
            k++;
        end
        chk("pushpop_reached", k < 2000, 1);
        wr(8'h96);
        chk("pushpop_empty", tx_empty, 0);
        chk("pushpop_full", tx_full, 0);
        chk("pushpop_busy", tx_busy, 1);
        wait_idle(4000);
        chk("pushpop_frame_count", frames_done - f0, 3);

        f0 = frames_done;
        p0 = n_push;
        for (int i = 0; i < 20; i++) begin
            wr(8'($urandom_range(0, 255)));
            step($urandom_range(0, 400));
        end
        wait_idle(20000);
        chk("random_frame_count", frames_done - f0, n_push - p0);

        // Reset mid-frame with bytes still queued; writes during reset must be ignored.
        wr(8'h11);
        wr(8'h22);
        wr(8'h33);
        k = 0;
        while (!(mon_active && mon_t == 200) && k < 2000) begin
            step(1);
            k++;
        end
        chk("abort_point_reached", k < 2000, 1);
        i_rst = 1'b1;
        wr_uart = 1'b1;
        w_data = 8'hC3;
        step(2);
        i_rst = 1'b0;
        wr_uart = 1'b0;
        f0 = frames_done;
        step(1500);
        chk("abort_no_frames", frames_done - f0, 0);
        chk("abort_tx_high", tx, 1);
        chk("abort_empty", tx_empty, 1);

        // DBIT=7, two stop bits: bit 7 of the written byte must never reach the line.
        for (int j = 0; j < 2; j++) begin
            byte7 = (j == 0) ? 8'hFF : 8'h80;
            wdata7 = byte7;
            wr7 = 1'b1;
            step(1);
            wr7 = 1'b0;
            for (int m = 1; m <= 700; m++) begin
                @(negedge i_clk);
                d = m - 3;
                if (d >= 0 && d < BIT)
                    exp_tx = 1'b0;
                else if (d >= BIT && d < BIT * 8)
                    exp_tx = byte7[d / BIT - 1];
                else
                    exp_tx = 1'b1;
                chk("dut7_tx", tx7, exp_tx);
                chk("dut7_done", done7, m == FRAME7 + 2);
                chk("dut7_busy", busy7, m >= 2 && m < FRAME7 + 2);
                chk("dut7_empty", empty7, m != 1);
                chk("dut7_full", full7, 0);
            end
            step(2);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
